// File: rtl/gesture_time_config.sv
// Edit-and-commit owner of the power gesture window; shows the setting on two
// scanned 7-segment digits that blink while the value is being edited.
module gesture_time_config #(
    parameter int CLKS_PER_SEC = 100_000_000,
    parameter int DEFAULT_SEC  = 5,
    parameter int MIN_SEC      = 1,
    parameter int MAX_SEC      = 10,
    parameter int TIMEOUT_SEC  = 10,
    parameter int SCAN_DIV     = 100_000,
    parameter int BLINK_DIV    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        power_status,
    input  logic        set_btn,
    input  logic        up_btn,
    input  logic        down_btn,
    output logic [29:0] gesture_time,
    output logic        editing,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);
    localparam int TIMEOUT_CYC = TIMEOUT_SEC * CLKS_PER_SEC;
    localparam int SCAN_W      = $clog2(SCAN_DIV + 1);
    localparam int BLINK_W     = $clog2(BLINK_DIV + 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t               state_q, state_d;
    logic                 set_prev_q, set_prev_d, up_prev_q, up_prev_d, down_prev_q, down_prev_d;
    logic                 press_set_q, press_set_d, press_up_q, press_up_d, press_down_q, press_down_d;
    logic [6:0]           cur_sec_q, cur_sec_d, edit_sec_q, edit_sec_d;
    logic [29:0]          gesture_time_q, gesture_time_d;
    logic                 editing_q, editing_d;
    logic [29:0]          timeout_q, timeout_d;
    logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic                 digit_sel_q, digit_sel_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [7:0]           seg_en_q, seg_en_d, seg_out_q, seg_out_d;
    logic [6:0]           shown, tens, units;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'h3F;
            4'd1:    seg_code = 8'h06;
            4'd2:    seg_code = 8'h5B;
            4'd3:    seg_code = 8'h4F;
            4'd4:    seg_code = 8'h66;
            4'd5:    seg_code = 8'h6D;
            4'd6:    seg_code = 8'h7D;
            4'd7:    seg_code = 8'h07;
            4'd8:    seg_code = 8'h7F;
            4'd9:    seg_code = 8'h6F;
            default: seg_code = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        cur_sec_d      = cur_sec_q;
        edit_sec_d     = edit_sec_q;
        gesture_time_d = gesture_time_q;
        timeout_d      = timeout_q;
        scan_cnt_d     = scan_cnt_q;
        digit_sel_d    = digit_sel_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        seg_en_d       = 8'h00;
        seg_out_d      = 8'h00;

        // Presses are registered one-shots, so the FSM acts one cycle after the edge is seen.
        set_prev_d   = set_btn;
        up_prev_d    = up_btn;
        down_prev_d  = down_btn;
        press_set_d  = set_btn & ~set_prev_q;
        press_up_d   = up_btn & ~up_prev_q;
        press_down_d = down_btn & ~down_prev_q;

        case (state_q)
            IDLE: begin
                if (press_set_q && power_status) begin
                    state_d    = EDIT;
                    edit_sec_d = cur_sec_q;
                    timeout_d  = '0;
                end
            end
            EDIT: begin
                if (!power_status) begin
                    state_d = IDLE;
                end else if (press_set_q) begin
                    state_d = COMMIT;
                end else if (press_up_q || press_down_q) begin
                    timeout_d = '0;
                    if (press_up_q && !press_down_q && edit_sec_q < 7'(MAX_SEC))
                        edit_sec_d = edit_sec_q + 7'd1;
                    else if (press_down_q && !press_up_q && edit_sec_q > 7'(MIN_SEC))
                        edit_sec_d = edit_sec_q - 7'd1;
                end else if (timeout_q == 30'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    timeout_d = timeout_q + 30'd1;
                end
            end
            COMMIT: begin
                cur_sec_d      = edit_sec_q;
                gesture_time_d = 30'(edit_sec_q) * 30'(CLKS_PER_SEC);
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        editing_d = (state_q == EDIT);

        if (!power_status) begin
            scan_cnt_d  = '0;
            digit_sel_d = 1'b0;
        end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt_d  = '0;
            digit_sel_d = ~digit_sel_q;
        end else begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end

        // Held at zero outside EDIT so each edit session starts in the visible phase.
        if (state_q != EDIT) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end

        shown = (state_q == EDIT) ? edit_sec_q : cur_sec_q;
        tens  = shown / 7'd10;
        units = shown % 7'd10;
        if (power_status && !(state_q == EDIT && blink_phase_q)) begin
            if (!digit_sel_q) begin
                seg_en_d  = 8'h01;
                seg_out_d = seg_code(units[3:0]);
            end else if (tens != 7'd0) begin
                seg_en_d  = 8'h02;
                seg_out_d = seg_code(tens[3:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            set_prev_q     <= 1'b0;
            up_prev_q      <= 1'b0;
            down_prev_q    <= 1'b0;
            press_set_q    <= 1'b0;
            press_up_q     <= 1'b0;
            press_down_q   <= 1'b0;
            cur_sec_q      <= 7'(DEFAULT_SEC);
            edit_sec_q     <= 7'(DEFAULT_SEC);
            gesture_time_q <= 30'(DEFAULT_SEC * CLKS_PER_SEC);
            editing_q      <= 1'b0;
            timeout_q      <= '0;
            scan_cnt_q     <= '0;
            digit_sel_q    <= 1'b0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            seg_en_q       <= 8'h00;
            seg_out_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            set_prev_q     <= set_prev_d;
            up_prev_q      <= up_prev_d;
            down_prev_q    <= down_prev_d;
            press_set_q    <= press_set_d;
            press_up_q     <= press_up_d;
            press_down_q   <= press_down_d;
            cur_sec_q      <= cur_sec_d;
            edit_sec_q     <= edit_sec_d;
            gesture_time_q <= gesture_time_d;
            editing_q      <= editing_d;
            timeout_q      <= timeout_d;
            scan_cnt_q     <= scan_cnt_d;
            digit_sel_q    <= digit_sel_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            seg_en_q       <= seg_en_d;
            seg_out_q      <= seg_out_d;
        end
    end

    assign gesture_time = gesture_time_q;
    assign editing      = editing_q;
    assign seg_en       = seg_en_q;
    assign seg_out      = seg_out_q;
endmodule

// File: tb/tb_gesture_time_config.sv
// Directed bench for gesture_time_config with small timing parameters:
// one second = 100 cycles, 4-cycle digit scan, 50-cycle blink half-period.
module tb_gesture_time_config;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        power_status = 1'b0;
    logic        set_btn = 1'b0;
    logic        up_btn = 1'b0;
    logic        down_btn = 1'b0;
    logic [29:0] gesture_time;
    logic        editing;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int checks = 0;
    int failures = 0;

    gesture_time_config #(
        .CLKS_PER_SEC(100),
        .DEFAULT_SEC (5),
        .MIN_SEC     (1),
        .MAX_SEC     (10),
        .TIMEOUT_SEC (10),
        .SCAN_DIV    (4),
        .BLINK_DIV   (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .power_status(power_status),
        .set_btn     (set_btn),
        .up_btn      (up_btn),
        .down_btn    (down_btn),
        .gesture_time(gesture_time),
        .editing     (editing),
        .seg_en      (seg_en),
        .seg_out     (seg_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic press(input logic s, input logic u, input logic d);
        set_btn  = s;
        up_btn   = u;
        down_btn = d;
        tick();
        set_btn  = 1'b0;
        up_btn   = 1'b0;
        down_btn = 1'b0;
        tick();
    endtask

    // Leaves the bench on the first sample where editing reads 1.
    task automatic enter_edit(input string tag);
        press(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (editing === 1'b1) break;
            tick();
        end
        chk(tag, 32'(editing), 32'd1);
    endtask

    task automatic commit(input string tag, input logic [29:0] exp_gt);
        press(1'b1, 1'b0, 1'b0);
        tick();
        chk({tag, "_gt"}, 32'(gesture_time), 32'(exp_gt));
        chk({tag, "_editing"}, 32'(editing), 32'd0);
    endtask

    initial begin
        logic       found;
        logic [7:0] prev_en;

        // Reset with power off
        repeat (3) tick();
        chk("rst_gt", 32'(gesture_time), 32'd500);
        chk("rst_editing", 32'(editing), 32'd0);
        chk("rst_seg_en", 32'(seg_en), 32'd0);
        chk("rst_seg_out", 32'(seg_out), 32'd0);
        rst = 1'b1;
        repeat (3) tick();
        chk("off_seg_en", 32'(seg_en), 32'd0);
        chk("off_seg_out", 32'(seg_out), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        tick();
        chk("off_set_ignored", 32'(editing), 32'd0);

        // Up saturates at 10, then exact commit latency
        power_status = 1'b1;
        repeat (2) tick();
        enter_edit("t2_enter");
        repeat (7) press(1'b0, 1'b1, 1'b0);
        set_btn = 1'b1;
        tick();
        chk("lat_n_gt", 32'(gesture_time), 32'd500);
        chk("lat_n_editing", 32'(editing), 32'd1);
        set_btn = 1'b0;
        tick();
        chk("lat_n1_gt", 32'(gesture_time), 32'd500);
        chk("lat_n1_editing", 32'(editing), 32'd1);
        tick();
        chk("lat_n2_gt", 32'(gesture_time), 32'd1000);
        chk("lat_n2_editing", 32'(editing), 32'd0);

        // Scan of "10" in IDLE: units 0 on digit 0, tens 1 on digit 1
        found = 1'b0;
        prev_en = seg_en;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (prev_en == 8'h01 && seg_en == 8'h02) begin
                found = 1'b1;
                break;
            end
            prev_en = seg_en;
        end
        chk("scan_found", 32'(found), 32'd1);
        chk("scan0_en", 32'(seg_en), 32'h02);
        chk("scan0_out", 32'(seg_out), 32'h06);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("scan_en", 32'(seg_en), (i < 4) ? 32'h02 : 32'h01);
            chk("scan_out", 32'(seg_out), (i < 4) ? 32'h06 : 32'h3F);
        end

        // Blink: visible for 50 cycles of EDIT, dark for the next 50
        enter_edit("blink_enter");
        chk("blink_j0", 32'(seg_en != 8'h00), 32'd1);
        for (int j = 1; j <= 100; j++) begin
            tick();
            if (j == 49 || j == 100)
                chk("blink_on", 32'(seg_en != 8'h00), 32'd1);
            else if (j == 50 || j == 75 || j == 99)
                chk("blink_off", 32'(seg_en), 32'd0);
        end
        commit("blink_commit", 30'd1000);

        // Reset in the middle of an edit
        enter_edit("rst_mid_enter");
        press(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        chk("rst_mid_gt", 32'(gesture_time), 32'd500);
        chk("rst_mid_editing", 32'(editing), 32'd0);
        chk("rst_mid_seg_en", 32'(seg_en), 32'd0);
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // Down saturates at 1
        enter_edit("t3_enter");
        repeat (9) press(1'b0, 1'b0, 1'b1);
        commit("t3_commit", 30'd100);

        // Simultaneous up+down is a no-op; a held button counts once
        enter_edit("t4_enter");
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b1);
        commit("t4_both", 30'd200);
        enter_edit("t4_hold_enter");
        up_btn = 1'b1;
        repeat (20) tick();
        up_btn = 1'b0;
        tick();
        commit("t4_hold", 30'd300);

        // Power drop discards the edit
        enter_edit("t5_enter");
        repeat (5) press(1'b0, 1'b1, 1'b0);
        power_status = 1'b0;
        repeat (3) tick();
        chk("pwr_drop_editing", 32'(editing), 32'd0);
        chk("pwr_drop_gt", 32'(gesture_time), 32'd300);
        chk("pwr_drop_seg_en", 32'(seg_en), 32'd0);
        power_status = 1'b1;
        repeat (2) tick();
        enter_edit("t5_reenter");
        press(1'b0, 1'b1, 1'b0);
        commit("t5_from_cur", 30'd400);

        // Inactivity timeout (1000 cycles after the last press) discards the edit
        enter_edit("to_enter");
        press(1'b0, 1'b1, 1'b0);
        repeat (990) tick();
        chk("to_before", 32'(editing), 32'd1);
        repeat (20) tick();
        chk("to_after", 32'(editing), 32'd0);
        chk("to_gt", 32'(gesture_time), 32'd400);
        enter_edit("to_reenter");
        commit("to_discarded", 30'd400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
